i2c_master_ctrl: RTL and testbench

Single-byte I2C bus master that drives the SCL/SDA pair into the team's I2C slave block. It generates SCL from CLK, issues START/STOP, and performs one register write (device, register, data) or one register read (device, register, repeated START, device, data) per request. ACK/NACK is checked after every byte sent. It sits between the host-side request logic and the I2C slave, in place of the stimulus that currently drives SCL/iSDA into the slave.

---
 rtl/i2c_master_ctrl.sv | 217 +++++++++++++++++++++
 tb/tb_i2c_master_ctrl.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_master_ctrl.sv
// Single-byte I2C master: one register write or one register read (with repeated START)
// per request, SCL derived from CLK in quarter-bit ticks, ACK checked after every sent byte.
module i2c_master_ctrl #(
    parameter int QTR = 32
) (
    input  logic       CLK,
    input  logic       Reset,
    input  logic       start,
    input  logic       rw,
    input  logic [6:0] dev_addr,
    input  logic [7:0] reg_addr,
    input  logic [7:0] wdata,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    output logic [7:0] rdata,
    output logic       SCL,
    output logic       oSDA,
    input  logic       iSDA
);

    localparam logic [3:0] ST_IDLE   = 4'd0;
    localparam logic [3:0] ST_START  = 4'd1;
    localparam logic [3:0] ST_ADDR_W = 4'd2;
    localparam logic [3:0] ST_ACK1   = 4'd3;
    localparam logic [3:0] ST_REG    = 4'd4;
    localparam logic [3:0] ST_ACK2   = 4'd5;
    localparam logic [3:0] ST_DATA_W = 4'd6;
    localparam logic [3:0] ST_ACK3   = 4'd7;
    localparam logic [3:0] ST_STOP   = 4'd8;
    localparam logic [3:0] ST_RSTART = 4'd9;
    localparam logic [3:0] ST_ADDR_R = 4'd10;
    localparam logic [3:0] ST_DATA_R = 4'd11;
    localparam logic [3:0] ST_MNACK  = 4'd12;
    localparam logic [3:0] ST_DONE   = 4'd13;

    localparam logic [7:0] QTR_M1 = 8'(QTR - 1);

    logic [3:0] state_q, state_d;
    logic [7:0] qcnt_q, qcnt_d;
    logic [1:0] phase_q, phase_d;
    logic [2:0] bit_q, bit_d;
    logic [7:0] rx_q, rx_d;
    logic [7:0] rdata_q, rdata_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       err_q, err_d;
    logic       scl_q, scl_d;
    logic       sda_q, sda_d;
    logic       rw_q;
    logic [6:0] dev_q;
    logic [7:0] reg_q;
    logic [7:0] wdata_q;
    logic [7:0] tx_byte;

    logic accept, tick, sample, slot_end, in_ack;

    assign accept   = start && !busy_q;
    assign tick     = (state_q != ST_IDLE) && (state_q != ST_DONE) && (qcnt_q == QTR_M1);
    // iSDA is sampled on the tick that enters P2, slot transitions happen on the tick leaving P3
    assign sample   = tick && (phase_q == 2'd1);
    assign slot_end = tick && (phase_q == 2'd3);
    assign in_ack   = (state_q == ST_ACK1) || (state_q == ST_ACK2) || (state_q == ST_ACK3);

    always_comb begin
        state_d = state_q;
        qcnt_d  = qcnt_q;
        phase_d = phase_q;
        bit_d   = bit_q;
        rx_d    = rx_q;
        rdata_d = rdata_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = err_q;
        if (accept) begin
            state_d = ST_START;
            qcnt_d  = 8'd0;
            phase_d = 2'd0;
            bit_d   = 3'd7;
            busy_d  = 1'b1;
            err_d   = 1'b0;
        end else if (state_q == ST_DONE) begin
            state_d = ST_IDLE;
        end else if (state_q != ST_IDLE) begin
            qcnt_d = tick ? 8'd0 : qcnt_q + 8'd1;
            if (tick) begin
                phase_d = phase_q + 2'd1;
            end
            if (sample) begin
                if (in_ack && iSDA) begin
                    err_d = 1'b1;
                end
                if (state_q == ST_DATA_R) begin
                    rx_d = {rx_q[6:0], iSDA};
                end
            end
            if (slot_end) begin
                case (state_q)
                    ST_START:  state_d = ST_ADDR_W;
                    ST_ADDR_W: begin
                        bit_d = bit_q - 3'd1;
                        if (bit_q == 3'd0) state_d = ST_ACK1;
                    end
                    ST_REG: begin
                        bit_d = bit_q - 3'd1;
                        if (bit_q == 3'd0) state_d = ST_ACK2;
                    end
                    ST_DATA_W: begin
                        bit_d = bit_q - 3'd1;
                        if (bit_q == 3'd0) state_d = ST_ACK3;
                    end
                    ST_ADDR_R: begin
                        bit_d = bit_q - 3'd1;
                        if (bit_q == 3'd0) state_d = ST_ACK3;
                    end
                    ST_DATA_R: begin
                        bit_d = bit_q - 3'd1;
                        if (bit_q == 3'd0) state_d = ST_MNACK;
                    end
                    ST_ACK1:   state_d = err_q ? ST_STOP : ST_REG;
                    ST_ACK2:   state_d = err_q ? ST_STOP : (rw_q ? ST_RSTART : ST_DATA_W);
                    ST_ACK3:   state_d = (err_q || !rw_q) ? ST_STOP : ST_DATA_R;
                    ST_RSTART: state_d = ST_ADDR_R;
                    ST_MNACK:  state_d = ST_STOP;
                    ST_STOP: begin
                        state_d = ST_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        if (rw_q && !err_q) rdata_d = rx_q;
                    end
                    default:   state_d = ST_IDLE;
                endcase
            end
        end
    end

    // Bus levels are decoded from the next state so SCL/oSDA come straight from flops
    always_comb begin
        tx_byte = 8'hFF;
        case (state_d)
            ST_ADDR_W: tx_byte = {dev_q, 1'b0};
            ST_REG:    tx_byte = reg_q;
            ST_DATA_W: tx_byte = wdata_q;
            ST_ADDR_R: tx_byte = {dev_q, 1'b1};
            default:   tx_byte = 8'hFF;
        endcase
    end

    always_comb begin
        scl_d = 1'b1;
        sda_d = 1'b1;
        case (state_d)
            ST_IDLE, ST_DONE: begin
                scl_d = 1'b1;
                sda_d = 1'b1;
            end
            ST_START, ST_RSTART: begin
                scl_d = !phase_d[1];
                sda_d = (phase_d == 2'd0);
            end
            ST_STOP: begin
                scl_d = (phase_d != 2'd0);
                sda_d = phase_d[1];
            end
            default: begin
                scl_d = phase_d[0] ^ phase_d[1];
                sda_d = tx_byte[bit_d];
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            qcnt_q  <= 8'd0;
            phase_q <= 2'd0;
            bit_q   <= 3'd7;
            rx_q    <= 8'd0;
            rdata_q <= 8'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            scl_q   <= 1'b1;
            sda_q   <= 1'b1;
            rw_q    <= 1'b0;
            dev_q   <= 7'd0;
            reg_q   <= 8'd0;
            wdata_q <= 8'd0;
        end else begin
            state_q <= state_d;
            qcnt_q  <= qcnt_d;
            phase_q <= phase_d;
            bit_q   <= bit_d;
            rx_q    <= rx_d;
            rdata_q <= rdata_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            scl_q   <= scl_d;
            sda_q   <= sda_d;
            if (accept) begin
                rw_q    <= rw;
                dev_q   <= dev_addr;
                reg_q   <= reg_addr;
                wdata_q <= wdata;
            end
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign ack_err = err_q;
    assign rdata   = rdata_q;
    assign SCL     = scl_q;
    assign oSDA    = sda_q;

endmodule

// File: tb/tb_i2c_master_ctrl.sv
// Bench for i2c_master_ctrl: protocol-level I2C slave on the bus plus a transaction-level
// model predicting bus tokens, transaction length, ack_err and rdata.
module tb_i2c_master_ctrl;

    localparam int QTR = 4;
    localparam logic [6:0] SLV_ID = 7'h0A;
    localparam int TOK_S = 256, TOK_P = 257, TOK_MNACK = 258, TOK_MACK = 259;
    localparam int MAXC = 200 * 4 * QTR;
    localparam int S_IDLE = 0, S_RX = 1, S_ACK = 2, S_TX = 3, S_MACK = 4;

    logic       CLK = 1'b0;
    logic       Reset = 1'b1;
    logic       start = 1'b0;
    logic       rw = 1'b0;
    logic [6:0] dev_addr = 7'd0;
    logic [7:0] reg_addr = 8'd0;
    logic [7:0] wdata = 8'd0;
    logic       busy, done, ack_err, SCL, oSDA, iSDA;
    logic [7:0] rdata;
    logic       sl_drv = 1'b1;
    logic       sda_line;

    int n_checks = 0;
    int n_pass = 0;

    assign sda_line = oSDA & sl_drv;
    assign iSDA = sda_line;

    always #5 CLK = ~CLK;

    i2c_master_ctrl #(.QTR(QTR)) dut (
        .CLK(CLK), .Reset(Reset), .start(start), .rw(rw), .dev_addr(dev_addr),
        .reg_addr(reg_addr), .wdata(wdata), .busy(busy), .done(done), .ack_err(ack_err),
        .rdata(rdata), .SCL(SCL), .oSDA(oSDA), .iSDA(iSDA)
    );

    // ---------------- I2C slave on the bus ----------------
    int         slv_log[$];
    logic [7:0] slv_mem[256];
    logic       nack_reg = 1'b0;
    logic       nack_data = 1'b0;
    int         sst = S_IDLE;
    int         sbit = 0;
    int         snbyte = 0;
    logic [7:0] ssh = 8'd0, sptr = 8'd0, stx = 8'd0;
    logic       s_ack = 1'b0, s_txnext = 1'b0, s_wr = 1'b0;
    logic       scl_p = 1'b1, sda_p = 1'b1;

    always @(negedge CLK) begin
        logic l_scl, l_sda;
        l_scl = SCL;
        l_sda = oSDA & sl_drv;
        if (Reset) begin
            sst = S_IDLE;
            sl_drv = 1'b1;
            l_scl = 1'b1;
            l_sda = 1'b1;
        end else if (scl_p && l_scl && sda_p && !l_sda) begin
            slv_log.push_back(TOK_S);
            sst = S_RX; sbit = 0; snbyte = 0; sl_drv = 1'b1;
        end else if (scl_p && l_scl && !sda_p && l_sda) begin
            slv_log.push_back(TOK_P);
            sst = S_IDLE; sl_drv = 1'b1;
        end else if (!scl_p && l_scl) begin
            if (sst == S_RX && sbit < 8) begin
                ssh = {ssh[6:0], l_sda};
                sbit++;
            end else if (sst == S_MACK) begin
                slv_log.push_back(l_sda ? TOK_MNACK : TOK_MACK);
            end
        end else if (scl_p && !l_scl) begin
            case (sst)
                S_RX: if (sbit == 8) begin
                    slv_log.push_back(int'(ssh));
                    s_txnext = 1'b0;
                    if (snbyte == 0) begin
                        s_ack = (ssh[7:1] == SLV_ID);
                        s_wr = !ssh[0];
                        s_txnext = s_ack && ssh[0];
                        stx = slv_mem[sptr];
                    end else if (snbyte == 1 && s_wr) begin
                        sptr = ssh;
                        s_ack = !nack_reg;
                    end else if (snbyte == 2 && s_wr) begin
                        s_ack = !nack_data;
                        if (s_ack) slv_mem[sptr] = ssh;
                    end else begin
                        s_ack = 1'b0;
                    end
                    snbyte++;
                    sst = S_ACK;
                    sl_drv = !s_ack;
                end
                S_ACK: begin
                    sl_drv = 1'b1;
                    sbit = 0;
                    if (!s_ack) sst = S_IDLE;
                    else if (s_txnext) begin
                        sst = S_TX; sl_drv = stx[7]; sbit = 1;
                    end else sst = S_RX;
                end
                S_TX: if (sbit == 8) begin
                    sl_drv = 1'b1; sst = S_MACK;
                end else begin
                    sl_drv = stx[3'(7 - sbit)]; sbit++;
                end
                S_MACK: sst = S_IDLE;
                default: ;
            endcase
        end
        scl_p = l_scl;
        sda_p = l_sda;
    end

    // ---------------- transaction-level reference model ----------------
    logic [7:0] ref_mem[256];
    int         exp_q[$];
    int         exp_lat;
    logic       exp_err;
    logic [7:0] exp_rdata = 8'd0;

    task automatic model_expect(input logic r, input logic [6:0] d, input logic [7:0] ra,
                                input logic [7:0] wd, input logic nreg, input logic ndat);
        int slots;
        exp_q.delete();
        exp_q.push_back(TOK_S);
        exp_q.push_back(int'({d, 1'b0}));
        if (d != SLV_ID) begin
            slots = 11; exp_err = 1'b1;
        end else begin
            exp_q.push_back(int'(ra));
            if (nreg) begin
                slots = 20; exp_err = 1'b1;
            end else if (!r) begin
                exp_q.push_back(int'(wd));
                slots = 29; exp_err = ndat;
                if (!ndat) ref_mem[ra] = wd;
            end else begin
                exp_q.push_back(TOK_S);
                exp_q.push_back(int'({d, 1'b1}));
                exp_q.push_back(TOK_MNACK);
                slots = 39; exp_err = 1'b0;
                exp_rdata = ref_mem[ra];
            end
        end
        exp_q.push_back(TOK_P);
        // done becomes visible just after edge E + 4*QTR*slots, i.e. in cycle E + 4*QTR*slots + 1
        exp_lat = slots * 4 * QTR;
    endtask

    function automatic int log_diff();
        if (slv_log.size() != exp_q.size()) return -2;
        foreach (exp_q[i]) if (slv_log[i] != exp_q[i]) return i;
        return -1;
    endfunction

    // Drives one request; called and returning #1 after a rising edge. lat = edges after
    // acceptance until done is seen (-1 timeout, -2 aborted by reset).
    task automatic do_txn(input logic r, input logic [6:0] d, input logic [7:0] ra,
                          input logic [7:0] wd, input int inject_at, input int abort_at,
                          output int lat, output logic saw_busy);
        slv_log.delete();
        rw = r; dev_addr = d; reg_addr = ra; wdata = wd; start = 1'b1;
        @(posedge CLK); #1;
        start = 1'b0;
        saw_busy = busy;
        lat = -1;
        for (int n = 0; n < MAXC; n++) begin
            if (done) begin lat = n; break; end
            if (n == inject_at) begin
                start = 1'b1; rw = ~r; dev_addr = ~d; reg_addr = ~ra; wdata = ~wd;
            end else if (n == inject_at + 1) begin
                start = 1'b0;
            end
            if (n == abort_at) begin
                Reset = 1'b1;
                @(posedge CLK); #1;
                Reset = 1'b0;
                lat = -2;
                break;
            end
            @(posedge CLK); #1;
        end
        start = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        int toggles;
        logic prev;
        Reset = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        n_checks++; if (SCL !== 1'b1) $display("FAIL rst_scl got %b want 1", SCL); else n_pass++;
        n_checks++; if (oSDA !== 1'b1) $display("FAIL rst_osda got %b want 1", oSDA); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL rst_busy got %b want 0", busy); else n_pass++;
        n_checks++; if (done !== 1'b0) $display("FAIL rst_done got %b want 0", done); else n_pass++;
        n_checks++; if (ack_err !== 1'b0) $display("FAIL rst_ack_err got %b want 0", ack_err); else n_pass++;
        n_checks++; if (rdata !== 8'h00) $display("FAIL rst_rdata got %h want 00", rdata); else n_pass++;
        Reset = 1'b0;
        toggles = 0;
        prev = SCL;
        repeat (500) begin
            @(posedge CLK); #1;
            if (SCL !== prev) toggles++;
            prev = SCL;
        end
        n_checks++; if (toggles != 0) $display("FAIL idle_scl_toggles got %0d want 0", toggles); else n_pass++;
        $display("reset: outputs checked, idle SCL toggles=%0d", toggles);
    endtask

    task automatic test_write();
        int lat, d;
        logic sb;
        model_expect(1'b0, 7'h0A, 8'h52, 8'h52, 1'b0, 1'b0);
        do_txn(1'b0, 7'h0A, 8'h52, 8'h52, -1, -1, lat, sb);
        d = log_diff();
        $display("write dev=0A reg=52 data=52 lat=%0d ack_err=%b", lat, ack_err);
        n_checks++; if (sb !== 1'b1) $display("FAIL wr_busy got %b want 1", sb); else n_pass++;
        n_checks++; if (lat != exp_lat) $display("FAIL wr_latency got %0d want %0d", lat, exp_lat); else n_pass++;
        n_checks++; if (ack_err !== exp_err) $display("FAIL wr_ack_err got %b want %b", ack_err, exp_err); else n_pass++;
        n_checks++; if (d != -1) $display("FAIL wr_bus_log diff %0d got %0d tokens want %0d", d, slv_log.size(), exp_q.size()); else n_pass++;
        n_checks++; if ({busy, SCL, oSDA} !== 3'b011) $display("FAIL wr_idle_bus got %b want 011", {busy, SCL, oSDA}); else n_pass++;
        n_checks++; if (slv_mem[8'h52] !== 8'h52) $display("FAIL wr_slave_mem got %h want 52", slv_mem[8'h52]); else n_pass++;
        @(posedge CLK); #1;
        n_checks++; if (done !== 1'b0) $display("FAIL wr_done_pulse got %b want 0", done); else n_pass++;
    endtask

    task automatic test_read();
        int lat, d;
        logic sb;
        slv_mem[8'hB5] = 8'hB5;
        ref_mem[8'hB5] = 8'hB5;
        model_expect(1'b1, 7'h0A, 8'hB5, 8'h00, 1'b0, 1'b0);
        do_txn(1'b1, 7'h0A, 8'hB5, 8'h00, -1, -1, lat, sb);
        d = log_diff();
        $display("read dev=0A reg=B5 lat=%0d rdata=%h ack_err=%b", lat, rdata, ack_err);
        n_checks++; if (lat != exp_lat) $display("FAIL rd_latency got %0d want %0d", lat, exp_lat); else n_pass++;
        n_checks++; if (ack_err !== exp_err) $display("FAIL rd_ack_err got %b want %b", ack_err, exp_err); else n_pass++;
        n_checks++; if (rdata !== exp_rdata) $display("FAIL rd_rdata got %h want %h", rdata, exp_rdata); else n_pass++;
        n_checks++; if (d != -1) $display("FAIL rd_bus_log diff %0d got %0d tokens want %0d", d, slv_log.size(), exp_q.size()); else n_pass++;
    endtask

    task automatic test_addr_nack();
        int lat, d;
        logic sb;
        model_expect(1'b0, 7'h55, 8'h11, 8'h22, 1'b0, 1'b0);
        do_txn(1'b0, 7'h55, 8'h11, 8'h22, -1, -1, lat, sb);
        d = log_diff();
        $display("write dev=55 (nack) lat=%0d ack_err=%b rdata=%h", lat, ack_err, rdata);
        n_checks++; if (lat != exp_lat) $display("FAIL nack_latency got %0d want %0d", lat, exp_lat); else n_pass++;
        n_checks++; if (ack_err !== 1'b1) $display("FAIL nack_ack_err got %b want 1", ack_err); else n_pass++;
        n_checks++; if (rdata !== exp_rdata) $display("FAIL nack_rdata got %h want %h", rdata, exp_rdata); else n_pass++;
        n_checks++; if (d != -1) $display("FAIL nack_bus_log diff %0d got %0d tokens want %0d", d, slv_log.size(), exp_q.size()); else n_pass++;
        repeat (3) @(posedge CLK);
        #1;
        n_checks++; if (ack_err !== 1'b1) $display("FAIL nack_err_held got %b want 1", ack_err); else n_pass++;
    endtask

    task automatic test_ignore_start();
        int lat, d;
        logic sb;
        logic [7:0] wd;
        wd = 8'($urandom);
        model_expect(1'b0, 7'h0A, 8'h33, wd, 1'b0, 1'b0);
        do_txn(1'b0, 7'h0A, 8'h33, wd, 100, -1, lat, sb);
        d = log_diff();
        $display("write with mid-txn start reg=33 data=%h lat=%0d", wd, lat);
        n_checks++; if (lat != exp_lat) $display("FAIL ign_latency got %0d want %0d", lat, exp_lat); else n_pass++;
        n_checks++; if (d != -1) $display("FAIL ign_bus_log diff %0d got %0d tokens want %0d", d, slv_log.size(), exp_q.size()); else n_pass++;
        n_checks++; if (slv_mem[8'h33] !== wd) $display("FAIL ign_slave_mem got %h want %h", slv_mem[8'h33], wd); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int lat, d;
        logic sb;
        // edge 170 after acceptance falls inside the REG byte (slots 10..17)
        do_txn(1'b0, 7'h0A, 8'h44, 8'h99, -1, 170, lat, sb);
        exp_rdata = 8'h00;
        $display("reset during REG byte: SCL=%b oSDA=%b busy=%b", SCL, oSDA, busy);
        n_checks++; if (lat != -2) $display("FAIL rmid_abort got %0d want -2", lat); else n_pass++;
        n_checks++; if ({SCL, oSDA, busy, done} !== 4'b1100) $display("FAIL rmid_lines got %b want 1100", {SCL, oSDA, busy, done}); else n_pass++;
        n_checks++; if (rdata !== 8'h00) $display("FAIL rmid_rdata got %h want 00", rdata); else n_pass++;
        model_expect(1'b0, 7'h0A, 8'h44, 8'h99, 1'b0, 1'b0);
        do_txn(1'b0, 7'h0A, 8'h44, 8'h99, -1, -1, lat, sb);
        d = log_diff();
        $display("write after reset reg=44 data=99 lat=%0d ack_err=%b", lat, ack_err);
        n_checks++; if (lat != exp_lat) $display("FAIL rmid_wr_latency got %0d want %0d", lat, exp_lat); else n_pass++;
        n_checks++; if (ack_err !== 1'b0) $display("FAIL rmid_wr_ack_err got %b want 0", ack_err); else n_pass++;
        n_checks++; if (d != -1) $display("FAIL rmid_bus_log diff %0d got %0d tokens want %0d", d, slv_log.size(), exp_q.size()); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int lat, d;
        logic sb;
        model_expect(1'b1, 7'h0A, 8'h44, 8'h00, 1'b0, 1'b0);
        do_txn(1'b1, 7'h0A, 8'h44, 8'h00, -1, -1, lat, sb);
        d = log_diff();
        $display("b2b read reg=44 lat=%0d rdata=%h", lat, rdata);
        n_checks++; if (lat != exp_lat) $display("FAIL b2b_rd_latency got %0d want %0d", lat, exp_lat); else n_pass++;
        n_checks++; if (rdata !== exp_rdata) $display("FAIL b2b_rdata got %h want %h", rdata, exp_rdata); else n_pass++;
        n_checks++; if (d != -1) $display("FAIL b2b_rd_log diff %0d got %0d tokens want %0d", d, slv_log.size(), exp_q.size()); else n_pass++;
        // issued while done is high: accepted on the next edge
        model_expect(1'b0, 7'h0A, 8'h45, 8'h3C, 1'b0, 1'b0);
        do_txn(1'b0, 7'h0A, 8'h45, 8'h3C, -1, -1, lat, sb);
        d = log_diff();
        $display("b2b write reg=45 data=3C lat=%0d busy_after_accept=%b", lat, sb);
        n_checks++; if (sb !== 1'b1) $display("FAIL b2b_busy got %b want 1", sb); else n_pass++;
        n_checks++; if (lat != exp_lat) $display("FAIL b2b_wr_latency got %0d want %0d", lat, exp_lat); else n_pass++;
        n_checks++; if (d != -1) $display("FAIL b2b_wr_log diff %0d got %0d tokens want %0d", d, slv_log.size(), exp_q.size()); else n_pass++;
    endtask

    task automatic test_random();
        int lat, d;
        logic sb, r, nr, nd;
        logic [6:0] dv;
        logic [7:0] ra, wd;
        for (int i = 0; i < 12; i++) begin
            r  = 1'($urandom);
            dv = SLV_ID;
            if ($urandom_range(0, 3) == 0) begin
                dv = 7'($urandom);
                if (dv == SLV_ID) dv = dv ^ 7'h01;
            end
            ra = 8'($urandom);
            wd = 8'($urandom);
            nr = ($urandom_range(0, 4) == 0);
            nd = ($urandom_range(0, 4) == 0);
            nack_reg = nr;
            nack_data = nd;
            model_expect(r, dv, ra, wd, nr, nd);
            do_txn(r, dv, ra, wd, -1, -1, lat, sb);
            d = log_diff();
            $display("rand %0d rw=%b dev=%h reg=%h wd=%h nr=%b nd=%b lat=%0d err=%b rdata=%h",
                     i, r, dv, ra, wd, nr, nd, lat, ack_err, rdata);
            n_checks++; if (lat != exp_lat) $display("FAIL rnd_latency got %0d want %0d", lat, exp_lat); else n_pass++;
            n_checks++; if (ack_err !== exp_err) $display("FAIL rnd_ack_err got %b want %b", ack_err, exp_err); else n_pass++;
            n_checks++; if (rdata !== exp_rdata) $display("FAIL rnd_rdata got %h want %h", rdata, exp_rdata); else n_pass++;
            n_checks++; if (d != -1) $display("FAIL rnd_bus_log diff %0d got %0d tokens want %0d", d, slv_log.size(), exp_q.size()); else n_pass++;
        end
        nack_reg = 1'b0;
        nack_data = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            slv_mem[i] = 8'($urandom);
            ref_mem[i] = slv_mem[i];
        end
        test_reset();
        test_write();
        test_read();
        test_addr_nack();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
